fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single write port of the simple FIFO between N producer channels. Each channel uses a valid/ready handshake. The arbiter grants one channel at a time and holds the grant for a bounded burst, then rotates priority. It sits between the producer agents/sources and the FIFO write interface, and exposes grant and beat-count status for checkers.

---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// A grant lasts until MAX_BURST beats are taken or the granted producer drops valid.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DW-1:0]      req_data,
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_wr_data,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam int GW = $clog2(N);
    localparam int BW = 4;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [GW-1:0]   r_grant_id;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   w_grant_next;
    logic [GW-1:0]   w_last_next;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_idx;
    logic [BW-1:0]   r_burst_cnt;
    logic [BW-1:0]   w_burst_next;
    logic [CNT_W-1:0] r_beat_cnt;
    logic            w_any;
    logic            w_gvalid;
    logic            w_beat;
    logic            w_busy;
    logic [DW-1:0]   w_ch_data [N];

    assign w_busy = (r_state == S_GRANT);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign w_ch_data[gi] = req_data[gi*DW +: DW];
            assign req_ready[gi] = w_busy && (r_grant_id == GW'(gi)) && !fifo_full;
        end
    endgenerate

    // First requester after the last granted channel, wrapping modulo N.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = GW'((int'(r_last_grant) + k) % N);
            if (!w_any && req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_gvalid = req_valid[r_grant_id];
    assign w_beat   = w_busy && w_gvalid && !fifo_full;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_last_next  = r_last_grant;
        w_burst_next = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_next = w_pick;
                    w_burst_next = '0;
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_beat) begin
                    w_burst_next = r_burst_cnt + 1'b1;
                end
                // A dropped request releases even with no beat taken.
                if (!w_gvalid || (w_beat && r_burst_cnt == BW'(MAX_BURST - 1))) begin
                    w_state_next = S_IDLE;
                    w_last_next  = r_grant_id;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(N - 1);
            r_burst_cnt  <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_next;
            r_last_grant <= w_last_next;
            r_burst_cnt  <= w_burst_next;
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign busy         = w_busy;
    assign fifo_wr_en   = w_beat;
    assign fifo_wr_data = w_ch_data[r_grant_id];
    assign grant_id     = r_grant_id;
    assign beat_cnt     = r_beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table plus hand-built multi-cycle sequences.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] beat_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .beat_cnt    (beat_cnt)
    );

    typedef struct {
        logic        rstn;
        logic [3:0]  valid;
        logic        full;
        logic [31:0] data;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [7:0]  e_wdata;
        logic [1:0]  e_gid;
        logic        e_busy;
        logic [15:0] e_beat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  wq[$];
    logic        p_rstn  = 1'b0;
    logic [3:0]  p_valid = 4'b0;
    logic [3:0]  p_ready = 4'b0;
    logic [31:0] p_data  = 32'b0;
    int          cnt[4];
    logic [15:0] exp_beat;
    vec_t        tbl[17];

    function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic f,
                                 input logic [31:0] d, input logic [3:0] er, input logic ew,
                                 input logic [7:0] ed, input logic [1:0] eg, input logic eb,
                                 input logic [15:0] ebt);
        vec_t x;
        x.rstn = r; x.valid = v; x.full = f; x.data = d;
        x.e_ready = er; x.e_wr = ew; x.e_wdata = ed; x.e_gid = eg; x.e_busy = eb; x.e_beat = ebt;
        return x;
    endfunction

    function automatic logic [7:0] dat(input int ch, input int k);
        return 8'(8'h40 + ch * 16 + k);
    endfunction

    function automatic logic [31:0] dch(input int ch, input int k);
        return 32'(dat(ch, k)) << (ch * 8);
    endfunction

    function automatic logic [31:0] dpack();
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = dat(i, cnt[i]);
        return d;
    endfunction

    function automatic logic [3:0] vmask();
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i] = (cnt[i] < 8);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, check outputs 1ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        if (p_rstn && v.rstn) begin
            for (int i = 0; i < 4; i++) begin
                if (p_valid[i] && !p_ready[i]) begin
                    checks++;
                    if (!v.valid[i] || v.data[i*8 +: 8] !== p_data[i*8 +: 8]) begin
                        errors++;
                        $display("FAIL producer_hold %s ch%0d: valid %0b data %0h, required held data %0h",
                                 tag, i, v.valid[i], v.data[i*8 +: 8], p_data[i*8 +: 8]);
                    end
                end
            end
        end
        rstn      = v.rstn;
        req_valid = v.valid;
        fifo_full = v.full;
        req_data  = v.data;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(v.e_ready));
        chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(v.e_wr));
        chk({tag, ".busy"},  32'(busy), 32'(v.e_busy));
        chk({tag, ".beat"},  32'(beat_cnt), 32'(v.e_beat));
        if (v.e_wr) chk({tag, ".wdata"}, 32'(fifo_wr_data), 32'(v.e_wdata));
        if (v.e_busy || !v.rstn) chk({tag, ".gid"}, 32'(grant_id), 32'(v.e_gid));
        if (fifo_wr_en) wq.push_back(fifo_wr_data);
        p_rstn  = v.rstn;
        p_valid = v.valid;
        p_ready = req_ready;
        p_data  = v.data;
    endtask

    task automatic do_reset(input string tag);
        apply(mkv(1'b0, 4'b0, 1'b0, 32'h0, 4'b0, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0), tag);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        exp_beat = 16'd0;
    endtask

    initial begin
        rstn = 1'b0; req_valid = 4'b0; fifo_full = 1'b0; req_data = 32'h0;

        // Reset/idle, then channel 2 streaming 0x10..0x17 in two bursts of four.
        for (int i = 0; i < 3; i++)
            tbl[i] = mkv(1'b0, 4'b0, 1'b0, 32'h0, 4'b0, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0);
        tbl[3]  = mkv(1'b1, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0);
        tbl[4]  = mkv(1'b1, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0);
        tbl[5]  = mkv(1'b1, 4'b0100, 1'b0, 32'h00100000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0);
        tbl[6]  = mkv(1'b1, 4'b0100, 1'b0, 32'h00100000, 4'b0100, 1'b1, 8'h10, 2'd2, 1'b1, 16'd0);
        tbl[7]  = mkv(1'b1, 4'b0100, 1'b0, 32'h00110000, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b1, 16'd1);
        tbl[8]  = mkv(1'b1, 4'b0100, 1'b0, 32'h00120000, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1, 16'd2);
        tbl[9]  = mkv(1'b1, 4'b0100, 1'b0, 32'h00130000, 4'b0100, 1'b1, 8'h13, 2'd2, 1'b1, 16'd3);
        tbl[10] = mkv(1'b1, 4'b0100, 1'b0, 32'h00140000, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd4);
        tbl[11] = mkv(1'b1, 4'b0100, 1'b0, 32'h00140000, 4'b0100, 1'b1, 8'h14, 2'd2, 1'b1, 16'd4);
        tbl[12] = mkv(1'b1, 4'b0100, 1'b0, 32'h00150000, 4'b0100, 1'b1, 8'h15, 2'd2, 1'b1, 16'd5);
        tbl[13] = mkv(1'b1, 4'b0100, 1'b0, 32'h00160000, 4'b0100, 1'b1, 8'h16, 2'd2, 1'b1, 16'd6);
        tbl[14] = mkv(1'b1, 4'b0100, 1'b0, 32'h00170000, 4'b0100, 1'b1, 8'h17, 2'd2, 1'b1, 16'd7);
        tbl[15] = mkv(1'b1, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd8);
        tbl[16] = mkv(1'b1, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd8);

        wq.delete();
        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        chk("stream.count", 32'(wq.size()), 32'd8);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            chk($sformatf("stream.fifo%0d", i), 32'(wq[i]), 32'(8'h10 + i));

        // All four channels continuously valid, eight beats each.
        do_reset("rr_rst");
        for (int g = 0; g < 8; g++) begin
            int ch;
            ch = g % 4;
            apply(mkv(1'b1, vmask(), 1'b0, dpack(), 4'b0, 1'b0, 8'h0, 2'd0, 1'b0, exp_beat),
                  $sformatf("rr_idle%0d", g));
            for (int b = 0; b < 4; b++) begin
                apply(mkv(1'b1, vmask(), 1'b0, dpack(), 4'(1 << ch), 1'b1, dat(ch, cnt[ch]),
                          2'(ch), 1'b1, exp_beat), $sformatf("rr_g%0d_b%0d", g, b));
                cnt[ch]++;
                exp_beat++;
            end
        end
        apply(mkv(1'b1, 4'b0, 1'b0, 32'h0, 4'b0, 1'b0, 8'h0, 2'd0, 1'b0, 16'd32), "rr_end");

        // fifo_full for five cycles after two beats of channel 1.
        do_reset("full_rst");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 0), 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0), "full_idle");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 0), 4'b0010, 1'b1, dat(1, 0), 2'd1, 1'b1, 16'd0), "full_b0");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 1), 4'b0010, 1'b1, dat(1, 1), 2'd1, 1'b1, 16'd1), "full_b1");
        for (int i = 0; i < 5; i++)
            apply(mkv(1'b1, 4'b0010, 1'b1, dch(1, 2), 4'b0000, 1'b0, 8'h0, 2'd1, 1'b1, 16'd2),
                  $sformatf("full_hold%0d", i));
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 2), 4'b0010, 1'b1, dat(1, 2), 2'd1, 1'b1, 16'd2), "full_b2");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 3), 4'b0010, 1'b1, dat(1, 3), 2'd1, 1'b1, 16'd3), "full_b3");
        apply(mkv(1'b1, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd4), "full_rel");

        // Channel 3 drops valid after one beat; channel 0 waits, then wins by wrap.
        do_reset("drop_rst");
        apply(mkv(1'b1, 4'b1000, 1'b0, dch(3, 0), 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0), "drop_idle");
        apply(mkv(1'b1, 4'b1001, 1'b0, dch(3, 0) | dch(0, 0), 4'b1000, 1'b1, dat(3, 0), 2'd3, 1'b1, 16'd0), "drop_b0");
        apply(mkv(1'b1, 4'b0001, 1'b0, dch(0, 0), 4'b1000, 1'b0, 8'h0, 2'd3, 1'b1, 16'd1), "drop_rel");
        apply(mkv(1'b1, 4'b0001, 1'b0, dch(0, 0), 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd1), "drop_arb");
        apply(mkv(1'b1, 4'b0001, 1'b0, dch(0, 0), 4'b0001, 1'b1, dat(0, 0), 2'd0, 1'b1, 16'd1), "drop_g0");
        apply(mkv(1'b1, 4'b0000, 1'b0, 32'h0, 4'b0001, 1'b0, 8'h0, 2'd0, 1'b1, 16'd2), "drop_g0rel");
        apply(mkv(1'b1, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd2), "drop_end");

        // Reset mid-burst of channel 1, then all channels request.
        do_reset("ar_rst0");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 0), 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0), "ar_idle");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 0), 4'b0010, 1'b1, dat(1, 0), 2'd1, 1'b1, 16'd0), "ar_b0");
        apply(mkv(1'b1, 4'b0010, 1'b0, dch(1, 1), 4'b0010, 1'b1, dat(1, 1), 2'd1, 1'b1, 16'd1), "ar_b1");
        cnt[1] = 2;
        apply(mkv(1'b0, 4'b1111, 1'b0, dpack(), 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0), "ar_reset");
        apply(mkv(1'b1, 4'b1111, 1'b0, dpack(), 4'b0000, 1'b0, 8'h0, 2'd0, 1'b0, 16'd0), "ar_arb");
        apply(mkv(1'b1, 4'b1111, 1'b0, dpack(), 4'b0001, 1'b1, dat(0, 0), 2'd0, 1'b1, 16'd0), "ar_g0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
